sim_frame_trigger: RTL and testbench

- Synthesizable producer of the frame count and dump-window signals consumed by the simulation dump controller in the MiST test harness.
- Counts frames on the falling edge of vertical sync.
- Optionally waits for the ROM download to end before counting.
- Asserts a dump window between a start frame and a frame length, and issues a one-shot finish request at a frame limit.
- Sits in the test harness alongside the game top; it also runs on hardware as a debug frame counter.

---
 rtl/sim_frame_trigger.sv | 134 +++++++++++++
 tb/tb_sim_frame_trigger.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_frame_trigger.sv
// Frame counter and dump-window generator for the simulation dump controller.
// Counts vs falling edges, optionally gated by the end of a ROM download.
module sim_frame_trigger #(
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned DUMP_FRAMES = 0,
  parameter int unsigned MAX_FRAMES  = 0,
  parameter bit          WAIT_DL     = 1'b0,
  parameter int unsigned DL_GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        downloading,
  output logic [31:0] frame_cnt,
  output logic        vs_fall,
  output logic        dump_en,
  output logic        dump_start,
  output logic        dump_stop,
  output logic        sim_finish,
  output logic [1:0]  st
);

  localparam int unsigned CNT_W   = 32;
  // Wide enough to hold DL_GUARD itself, and at least one bit when DL_GUARD is 0
  localparam int unsigned GUARD_W = $clog2(DL_GUARD + 2);

  typedef enum logic [1:0] {
    WAITDL  = 2'd0,
    ARMED   = 2'd1,
    DUMPING = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state;
  logic               vs_l;
  logic               dl_l;
  logic               fin_seen;
  logic [GUARD_W-1:0] guard_cnt;
  logic [CNT_W-1:0]   win_cnt;

  logic               guard_done_c;
  logic               fall_c;
  logic               dlend_c;
  logic               dlrise_c;
  logic               restart_c;
  logic [CNT_W-1:0]   frame_inc_c;
  logic [CNT_W-1:0]   win_inc_c;

  assign guard_done_c = (guard_cnt == GUARD_W'(DL_GUARD));
  assign fall_c       = vs_l & ~vs;
  assign dlend_c      = dl_l & ~downloading & guard_done_c;
  assign dlrise_c     = ~dl_l & downloading;
  assign restart_c    = WAIT_DL && dlrise_c && (state != WAITDL);
  assign frame_inc_c  = frame_cnt + CNT_W'(1);
  assign win_inc_c    = win_cnt + CNT_W'(1);
  assign st           = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_DL ? WAITDL : ARMED;
      vs_l       <= 1'b0;
      dl_l       <= 1'b0;
      fin_seen   <= 1'b0;
      guard_cnt  <= '0;
      win_cnt    <= '0;
      frame_cnt  <= '0;
      vs_fall    <= 1'b0;
      dump_en    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      sim_finish <= 1'b0;
    end else begin
      vs_l       <= vs;
      dl_l       <= downloading;
      vs_fall    <= fall_c;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      sim_finish <= 1'b0;

      if (!guard_done_c) begin
        guard_cnt <= guard_cnt + GUARD_W'(1);
      end

      // A new download outranks every frame event in the same cycle
      if (restart_c) begin
        state     <= WAITDL;
        frame_cnt <= '0;
        fin_seen  <= 1'b0;
        if (dump_en) begin
          dump_stop <= 1'b1;
          dump_en   <= 1'b0;
        end
      end else if (state == WAITDL) begin
        frame_cnt <= '0;
        if (dlend_c) begin
          state <= ARMED;
        end
      end else begin
        if (fall_c) begin
          frame_cnt <= frame_inc_c;
          if ((MAX_FRAMES != 0) && (frame_inc_c == CNT_W'(MAX_FRAMES)) && !fin_seen) begin
            sim_finish <= 1'b1;
            fin_seen   <= 1'b1;
          end
        end

        case (state)
          ARMED: begin
            // Window opens against the count before this frame's increment
            if ((START_FRAME == 0) || (fall_c && (frame_cnt == CNT_W'(START_FRAME)))) begin
              state      <= DUMPING;
              dump_start <= 1'b1;
              dump_en    <= 1'b1;
              win_cnt    <= '0;
            end
          end
          DUMPING: begin
            if (fall_c) begin
              win_cnt <= win_inc_c;
              if ((DUMP_FRAMES != 0) && (win_inc_c == CNT_W'(DUMP_FRAMES))) begin
                dump_stop <= 1'b1;
                dump_en   <= 1'b0;
                state     <= DONE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sim_frame_trigger.sv
// Self-checking bench for sim_frame_trigger: three configurations share clk, rst, vs
// and downloading; per-frame expectations are queued when vs falls and checked on vs_fall.
module tb_sim_frame_trigger;

  logic clk;
  logic rst;
  logic vs;
  logic downloading;

  logic [31:0] a_fc, b_fc, c_fc;
  logic        a_vf, b_vf, c_vf;
  logic        a_en, b_en, c_en;
  logic        a_start, b_start, c_start;
  logic        a_stop, b_stop, c_stop;
  logic        a_fin, b_fin, c_fin;
  logic [1:0]  a_st, b_st, c_st;

  int n_cmp;
  int n_err;
  int cyc;
  int a_vf_cnt;
  int a_start_cnt;
  int a_fin_cnt;
  int c_fin_cnt;

  typedef struct {
    int unsigned idx;
    logic [31:0] a_fc;
    logic        a_start;
    logic        a_stop;
    logic        a_fin;
    logic        a_en;
    logic [1:0]  a_st;
    logic [31:0] b_fc;
    logic [31:0] c_fc;
    logic        c_fin;
  } exp_t;

  exp_t sb_q[$];

  // Window 3..+2 frames, finish at 4
  sim_frame_trigger #(
    .START_FRAME(3), .DUMP_FRAMES(2), .MAX_FRAMES(4), .WAIT_DL(1'b0), .DL_GUARD(16)
  ) u_a (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(a_fc), .vs_fall(a_vf), .dump_en(a_en), .dump_start(a_start),
    .dump_stop(a_stop), .sim_finish(a_fin), .st(a_st)
  );

  // Immediate, never-closing window
  sim_frame_trigger #(
    .START_FRAME(0), .DUMP_FRAMES(0), .MAX_FRAMES(0), .WAIT_DL(1'b0), .DL_GUARD(16)
  ) u_b (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(b_fc), .vs_fall(b_vf), .dump_en(b_en), .dump_start(b_start),
    .dump_stop(b_stop), .sim_finish(b_fin), .st(b_st)
  );

  // Download-gated, finish at 2
  sim_frame_trigger #(
    .START_FRAME(0), .DUMP_FRAMES(0), .MAX_FRAMES(2), .WAIT_DL(1'b1), .DL_GUARD(16)
  ) u_c (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(c_fc), .vs_fall(c_vf), .dump_en(c_en), .dump_start(c_start),
    .dump_stop(c_stop), .sim_finish(c_fin), .st(c_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_vf === 1'b1)    a_vf_cnt++;
    if (a_start === 1'b1) a_start_cnt++;
    if (a_fin === 1'b1)   a_fin_cnt++;
    if (c_fin === 1'b1)   c_fin_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d required=end_of_test", cyc);
    $fatal(1, "bench did not complete");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One vs pulse (10 high, 20 low); expectations are queued at the falling edge
  task automatic do_frame(input int unsigned idx, input logic [31:0] exp_c_fc, input logic exp_c_fin);
    exp_t e;
    bit   got;
    int   lat;
    vs = 1'b1;
    repeat (10) tick();
    vs = 1'b0;
    e.idx     = idx;
    e.a_fc    = idx;
    e.a_start = (idx == 4);
    e.a_stop  = (idx == 6);
    e.a_fin   = (idx == 4);
    e.a_en    = (idx == 4) || (idx == 5);
    e.a_st    = (idx < 4) ? 2'd1 : ((idx < 6) ? 2'd2 : 2'd3);
    e.b_fc    = idx;
    e.c_fc    = exp_c_fc;
    e.c_fin   = exp_c_fin;
    sb_q.push_back(e);
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      if (!got) begin
        tick();
        lat++;
        if (a_vf === 1'b1) got = 1'b1;
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL vs_fall_timeout frame=%0d got=no_pulse required=pulse", idx);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if (lat !== 1) begin n_err++; $display("FAIL vs_fall_latency frame=%0d got=%0d required=1", e.idx, lat); end
      n_cmp++;
      if (a_fc !== e.a_fc) begin n_err++; $display("FAIL a_frame_cnt frame=%0d got=%0d required=%0d", e.idx, a_fc, e.a_fc); end
      n_cmp++;
      if (a_start !== e.a_start) begin n_err++; $display("FAIL a_dump_start frame=%0d got=%b required=%b", e.idx, a_start, e.a_start); end
      n_cmp++;
      if (a_stop !== e.a_stop) begin n_err++; $display("FAIL a_dump_stop frame=%0d got=%b required=%b", e.idx, a_stop, e.a_stop); end
      n_cmp++;
      if (a_fin !== e.a_fin) begin n_err++; $display("FAIL a_sim_finish frame=%0d got=%b required=%b", e.idx, a_fin, e.a_fin); end
      n_cmp++;
      if (a_en !== e.a_en) begin n_err++; $display("FAIL a_dump_en frame=%0d got=%b required=%b", e.idx, a_en, e.a_en); end
      n_cmp++;
      if (a_st !== e.a_st) begin n_err++; $display("FAIL a_st frame=%0d got=%0d required=%0d", e.idx, a_st, e.a_st); end
      n_cmp++;
      if (b_fc !== e.b_fc) begin n_err++; $display("FAIL b_frame_cnt frame=%0d got=%0d required=%0d", e.idx, b_fc, e.b_fc); end
      n_cmp++;
      if (c_fc !== e.c_fc) begin n_err++; $display("FAIL c_frame_cnt frame=%0d got=%0d required=%0d", e.idx, c_fc, e.c_fc); end
      n_cmp++;
      if (c_fin !== e.c_fin) begin n_err++; $display("FAIL c_sim_finish frame=%0d got=%b required=%b", e.idx, c_fin, e.c_fin); end
    end
    tick();
    n_cmp++;
    if (a_vf !== 1'b0) begin n_err++; $display("FAIL vs_fall_width frame=%0d got=%b required=0", idx, a_vf); end
    repeat (18) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vs = 1'b0;
    downloading = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (a_fc !== 32'd0 || b_fc !== 32'd0 || c_fc !== 32'd0) begin
      n_err++; $display("FAIL reset_frame_cnt got=%0d/%0d/%0d required=0/0/0", a_fc, b_fc, c_fc);
    end
    n_cmp++;
    if ({a_vf, a_en, a_start, a_stop, a_fin, b_vf, b_en, b_start, b_stop, b_fin,
         c_vf, c_en, c_start, c_stop, c_fin} !== 15'd0) begin
      n_err++; $display("FAIL reset_flags got=%b%b%b%b%b required=00000 (a)", a_vf, a_en, a_start, a_stop, a_fin);
    end
    n_cmp++;
    if (a_st !== 2'd1 || b_st !== 2'd1 || c_st !== 2'd0) begin
      n_err++; $display("FAIL reset_st got=%0d/%0d/%0d required=1/1/0", a_st, b_st, c_st);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_immediate_start();
    tick();
    n_cmp++;
    if (b_start !== 1'b1) begin n_err++; $display("FAIL b_immediate_start cyc=%0d got=%b required=1", cyc, b_start); end
    n_cmp++;
    if (b_st !== 2'd2 || b_en !== 1'b1) begin n_err++; $display("FAIL b_immediate_state got st=%0d en=%b required st=2 en=1", b_st, b_en); end
    n_cmp++;
    if (a_st !== 2'd1 || a_start !== 1'b0) begin n_err++; $display("FAIL a_stays_armed got st=%0d start=%b required st=1 start=0", a_st, a_start); end
    tick();
    n_cmp++;
    if (b_start !== 1'b0 || b_en !== 1'b1) begin n_err++; $display("FAIL b_start_width got start=%b en=%b required start=0 en=1", b_start, b_en); end
  endtask

  task automatic test_download_gating();
    while (cyc < 5) tick();
    downloading = 1'b0;
    tick();
    n_cmp++;
    if (c_st !== 2'd0) begin n_err++; $display("FAIL c_guard_ignore cyc=%0d got st=%0d required=0", cyc, c_st); end
    while (cyc < 30) tick();
    n_cmp++;
    if (c_st !== 2'd0 || c_fc !== 32'd0) begin n_err++; $display("FAIL c_still_waiting got st=%0d fc=%0d required st=0 fc=0", c_st, c_fc); end
    downloading = 1'b1;
    while (cyc < 50) tick();
    downloading = 1'b0;
    tick();
    n_cmp++;
    if (c_st !== 2'd1) begin n_err++; $display("FAIL c_armed cyc=%0d got st=%0d required=1", cyc, c_st); end
    n_cmp++;
    if (c_fc !== 32'd0) begin n_err++; $display("FAIL c_armed_fc got=%0d required=0", c_fc); end
    n_cmp++;
    if (b_st !== 2'd2 || a_st !== 2'd1) begin n_err++; $display("FAIL dl_ignored got a=%0d b=%0d required a=1 b=2", a_st, b_st); end
    tick();
    n_cmp++;
    if (c_st !== 2'd2 || c_start !== 1'b1) begin n_err++; $display("FAIL c_dump_open got st=%0d start=%b required st=2 start=1", c_st, c_start); end
    repeat (3) tick();
  endtask

  task automatic test_basic_count();
    for (int i = 1; i <= 5; i++) do_frame(i, 32'(i), (i == 2));
    n_cmp++;
    if (a_fc !== 32'd5) begin n_err++; $display("FAIL basic_count got=%0d required=5", a_fc); end
    n_cmp++;
    if (a_vf_cnt !== 5) begin n_err++; $display("FAIL vs_fall_pulses got=%0d required=5", a_vf_cnt); end
  endtask

  task automatic test_window_finish();
    for (int i = 6; i <= 14; i++) do_frame(i, 32'(i), 1'b0);
    n_cmp++;
    if (a_st !== 2'd3 || a_en !== 1'b0) begin n_err++; $display("FAIL a_done got st=%0d en=%b required st=3 en=0", a_st, a_en); end
    n_cmp++;
    if (a_fin_cnt !== 1) begin n_err++; $display("FAIL a_finish_once got=%0d required=1", a_fin_cnt); end
    n_cmp++;
    if (a_start_cnt !== 1) begin n_err++; $display("FAIL a_start_once got=%0d required=1", a_start_cnt); end
    n_cmp++;
    if (c_fin_cnt !== 1) begin n_err++; $display("FAIL c_finish_once got=%0d required=1", c_fin_cnt); end
  endtask

  task automatic test_restart_mid_dump();
    n_cmp++;
    if (c_st !== 2'd2 || c_en !== 1'b1) begin n_err++; $display("FAIL c_pre_restart got st=%0d en=%b required st=2 en=1", c_st, c_en); end
    downloading = 1'b1;
    tick();
    n_cmp++;
    if (c_stop !== 1'b1 || c_start !== 1'b0) begin n_err++; $display("FAIL c_restart_pulse got stop=%b start=%b required stop=1 start=0", c_stop, c_start); end
    n_cmp++;
    if (c_en !== 1'b0 || c_fc !== 32'd0 || c_st !== 2'd0) begin
      n_err++; $display("FAIL c_restart_state got en=%b fc=%0d st=%0d required en=0 fc=0 st=0", c_en, c_fc, c_st);
    end
    n_cmp++;
    if (b_st !== 2'd2 || b_en !== 1'b1 || a_st !== 2'd3) begin n_err++; $display("FAIL restart_isolated got a=%0d b=%0d required a=3 b=2", a_st, b_st); end
    tick();
    n_cmp++;
    if (c_stop !== 1'b0) begin n_err++; $display("FAIL c_stop_width got=%b required=0", c_stop); end
    do_frame(15, 32'd0, 1'b0);
    downloading = 1'b0;
    tick();
    n_cmp++;
    if (c_st !== 2'd1 || c_fc !== 32'd0) begin n_err++; $display("FAIL c_rearm got st=%0d fc=%0d required st=1 fc=0", c_st, c_fc); end
    tick();
    n_cmp++;
    if (c_st !== 2'd2 || c_start !== 1'b1) begin n_err++; $display("FAIL c_reopen got st=%0d start=%b required st=2 start=1", c_st, c_start); end
    do_frame(16, 32'd1, 1'b0);
    do_frame(17, 32'd2, 1'b1);
    n_cmp++;
    if (c_fin_cnt !== 2) begin n_err++; $display("FAIL c_finish_rearmed got=%0d required=2", c_fin_cnt); end
  endtask

  task automatic test_reset_mid_dump();
    n_cmp++;
    if (c_st !== 2'd2 || b_st !== 2'd2) begin n_err++; $display("FAIL pre_reset_dumping got b=%0d c=%0d required 2/2", b_st, c_st); end
    vs = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    vs = 1'b0;
    tick();
    n_cmp++;
    if (a_fc !== 32'd0 || b_fc !== 32'd0 || c_fc !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_frame_cnt got=%0d/%0d/%0d required=0/0/0", a_fc, b_fc, c_fc);
    end
    n_cmp++;
    if ({a_vf, b_vf, c_vf} !== 3'b000) begin n_err++; $display("FAIL rst_mid_vs_fall got=%b required=000", {a_vf, b_vf, c_vf}); end
    n_cmp++;
    if ({a_en, b_en, c_en, a_start, b_start, c_start, a_stop, b_stop, c_stop, a_fin, b_fin, c_fin} !== 12'd0) begin
      n_err++; $display("FAIL rst_mid_flags got en=%b%b%b stop=%b%b%b required en=000 stop=000", a_en, b_en, c_en, a_stop, b_stop, c_stop);
    end
    n_cmp++;
    if (a_st !== 2'd1 || b_st !== 2'd1 || c_st !== 2'd0) begin
      n_err++; $display("FAIL rst_mid_st got=%0d/%0d/%0d required=1/1/0", a_st, b_st, c_st);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    a_vf_cnt = 0;
    a_start_cnt = 0;
    a_fin_cnt = 0;
    c_fin_cnt = 0;
    rst = 1'b1;
    vs = 1'b0;
    downloading = 1'b1;
    test_reset();
    test_immediate_start();
    test_download_gating();
    test_basic_count();
    test_window_finish();
    test_restart_mid_dump();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
